// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm zone controller: door counts and FSM state encoding.
package alarm_pkg;

  localparam int NUM_DOORS       = 5;
  localparam int NUM_ALARM_ZONES = 4;
  localparam int ENTRY_DOOR_IDX  = 4;

  // Prefixed so the names cannot collide with the delay parameters of the top.
  typedef enum logic [2:0] {
    ST_DISARMED    = 3'd0,
    ST_EXIT_DELAY  = 3'd1,
    ST_ARMED       = 3'd2,
    ST_ENTRY_DELAY = 3'd3,
    ST_ALARM       = 3'd4
  } alarm_state_e;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/door_debounce.sv
// One door contact: 2-flop synchroniser followed by a stable-count debouncer.
module door_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic door_raw,
  output logic opening
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync_1;
  logic          sync_2;
  logic [CW-1:0] count;

  // The flip happens on the cycle the count would reach DEBOUNCE_CYCLES.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_1  <= 1'b0;
      sync_2  <= 1'b0;
      count   <= '0;
      opening <= 1'b0;
    end else begin
      sync_1 <= door_raw;
      sync_2 <= sync_1;
      if (sync_2 == opening) begin
        count <= '0;
      end else if (count == CW'(DEBOUNCE_CYCLES - 1)) begin
        opening <= ~opening;
        count   <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/alarm_zone_controller.sv
// Debounced door inputs plus arm/disarm/entry-delay/alarm FSM with a shared delay timer.
// Optional: define ALARM_AUTO_RESET_EN to drop the siren after SIREN_TIMEOUT and re-arm.
module alarm_zone_controller
  import alarm_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int EXIT_DELAY      = 1000,
  parameter int ENTRY_DELAY     = 1000,
  parameter int SIREN_TIMEOUT   = 5000
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_DOORS-1:0]       door_raw,
  input  logic                       arm_req,
  input  logic                       disarm_req,
  output logic [NUM_DOORS-1:0]       opening,
  output logic [NUM_ALARM_ZONES-1:0] alarm,
  output logic                       siren,
  output logic                       arm_reject,
  output logic [2:0]                 state
);

  localparam int MAX_DELAY = max_of(max_of(EXIT_DELAY, ENTRY_DELAY), SIREN_TIMEOUT);
  localparam int TW        = $clog2(MAX_DELAY + 1);

  alarm_state_e               state_q, state_next;
  logic [TW-1:0]              timer_q, timer_next;
  logic [NUM_ALARM_ZONES-1:0] alarm_q, alarm_next;
  logic                       siren_q, reject_q, reject_next;
  logic                       zone_open;

  for (genvar i = 0; i < NUM_DOORS; i++) begin : g_door
    door_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
      .clk     (clk),
      .reset_n (reset_n),
      .door_raw(door_raw[i]),
      .opening (opening[i])
    );
  end

  assign zone_open = |opening[NUM_ALARM_ZONES-1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_DISARMED;
      timer_q  <= '0;
      alarm_q  <= '0;
      siren_q  <= 1'b0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_next;
      timer_q  <= timer_next;
      alarm_q  <= alarm_next;
      siren_q  <= (state_next == ST_ALARM);
      reject_q <= reject_next;
    end
  end

  // The timer counts down to zero every cycle; states that need it reload it on entry.
  always_comb begin
    state_next  = state_q;
    timer_next  = (timer_q != '0) ? timer_q - 1'b1 : '0;
    alarm_next  = alarm_q;
    reject_next = 1'b0;
    case (state_q)
      ST_DISARMED: begin
        if (arm_req && !disarm_req) begin
          if (opening == '0) begin
            state_next = ST_EXIT_DELAY;
            timer_next = TW'(EXIT_DELAY);
            alarm_next = '0;
          end else begin
            reject_next = 1'b1;
          end
        end
      end
      ST_EXIT_DELAY: begin
        if (disarm_req) state_next = ST_DISARMED;
        else if (timer_q <= TW'(1)) state_next = ST_ARMED;
      end
      ST_ARMED: begin
        if (disarm_req) begin
          state_next = ST_DISARMED;
        end else if (zone_open) begin
          state_next = ST_ALARM;
          alarm_next = alarm_q | opening[NUM_ALARM_ZONES-1:0];
          timer_next = TW'(SIREN_TIMEOUT);
        end else if (opening[ENTRY_DOOR_IDX]) begin
          state_next = ST_ENTRY_DELAY;
          timer_next = TW'(ENTRY_DELAY);
        end
      end
      ST_ENTRY_DELAY: begin
        if (disarm_req) begin
          state_next = ST_DISARMED;
        end else if (zone_open || timer_q <= TW'(1)) begin
          state_next = ST_ALARM;
          alarm_next = alarm_q | opening[NUM_ALARM_ZONES-1:0];
          timer_next = TW'(SIREN_TIMEOUT);
        end
      end
      ST_ALARM: begin
        if (disarm_req) begin
          state_next = ST_DISARMED;
        end else begin
          alarm_next = alarm_q | opening[NUM_ALARM_ZONES-1:0];
`ifdef ALARM_AUTO_RESET_EN
          if (timer_q <= TW'(1)) state_next = ST_ARMED;
`endif
        end
      end
      default: state_next = ST_DISARMED;
    endcase
  end

  assign alarm      = alarm_q;
  assign siren      = siren_q;
  assign arm_reject = reject_q;
  assign state      = state_q;

endmodule

// File: doc/alarm_zone_controller.md
Name: alarm_zone_controller

Overview:
- Upstream stage of the alarm display top level. Debounces five raw door contacts and runs the arm/disarm/entry-delay/alarm state machine.
- Produces the `opening[4:0]` and `alarm[3:0]` status vectors that the display multiplexer consumes, plus a siren drive.
- Doors 0-3 are instant zones. Door 4 is the entry door and is delayed.

Parameters:
- `DEBOUNCE_CYCLES`, 16: consecutive stable cycles required before a debounced door changes.
- `EXIT_DELAY`, 1000: cycles spent in EXIT_DELAY after a successful arm.
- `ENTRY_DELAY`, 1000: cycles allowed to disarm after door 4 opens while armed.
- `SIREN_TIMEOUT`, 5000: siren on-time; used only with `ALARM_AUTO_RESET_EN`.

Ports:
- `clk` input 1: system clock, all logic on rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `door_raw` input 5: raw contacts, 1 = open, asynchronous to `clk`.
- `arm_req` input 1: single-cycle arm request.
- `disarm_req` input 1: single-cycle disarm request.
- `opening` output 5: debounced door status, 1 = open.
- `alarm` output 4: latched trip flags for doors 0-3.
- `siren` output 1: 1 while in ALARM.
- `arm_reject` output 1: one-cycle pulse when an arm attempt is refused.
- `state` output 3: current FSM state encoding, for debug and display.

Behaviour:
- Reset (`reset_n` low, asynchronous):
  - `opening`=0, `alarm`=0, `siren`=0, `arm_reject`=0, `state`=DISARMED.
  - Debounce counters and the timer are 0; synchroniser flops are 0.
  - Reset asserted mid-delay or mid-alarm aborts immediately, with no residual siren.
- Input sync: each `door_raw` bit passes through a 2-flop synchroniser.
- Debounce, per door:
  - The counter increments while the synced bit differs from `opening[i]` and clears when they match.
  - When the count reaches `DEBOUNCE_CYCLES`, `opening[i]` flips and the counter clears.
  - Latency from a stable raw edge to `opening` is `DEBOUNCE_CYCLES` + 2 cycles.
  - A glitch shorter than `DEBOUNCE_CYCLES` never reaches `opening`.
- The FSM acts on registered `opening` only. States: DISARMED=0, EXIT_DELAY=1, ARMED=2, ENTRY_DELAY=3, ALARM=4.
- DISARMED:
  - `arm_req` with `opening`==0 goes to EXIT_DELAY, loads timer=`EXIT_DELAY`, and clears `alarm` flags.
  - `arm_req` with any door open stays in DISARMED and pulses `arm_reject` for 1 cycle the next cycle.
- EXIT_DELAY:
  - Timer decrements each cycle; ARMED is entered exactly `EXIT_DELAY` cycles after the arm request cycle.
  - Door activity is ignored.
  - `disarm_req` goes to DISARMED.
- ARMED:
  - Any `opening[3:0]` set goes to ALARM; `alarm[i]` |= `opening[i]`.
  - Else `opening[4]` goes to ENTRY_DELAY with timer=`ENTRY_DELAY`.
  - `disarm_req` goes to DISARMED.
  - If a door 0-3 trip and door 4 occur in the same cycle, ALARM wins.
- ENTRY_DELAY:
  - `disarm_req` goes to DISARMED.
  - Any `opening[3:0]` goes to ALARM at once, setting the flags.
  - Timer expiry after `ENTRY_DELAY` cycles goes to ALARM, with `alarm` unchanged.
- ALARM:
  - `siren`=1.
  - Further door 0-3 openings OR into `alarm`.
  - `disarm_req` goes to DISARMED with `siren`=0; `alarm` flags are retained for the display until the next accepted arm.
- Priority: `disarm_req` beats `arm_req` in the same cycle. `arm_req` is ignored in every state except DISARMED.
- Timer width is `$clog2` of the maximum delay + 1. The timer saturates at 0 and never wraps.
- `siren` and `state` are registered outputs with no combinational path from inputs.

Optional Feature:
- `ALARM_AUTO_RESET_EN` defined:
  - ALARM loads timer=`SIREN_TIMEOUT` on entry.
  - On expiry, `siren` drops and the FSM returns to ARMED with `alarm` flags retained.
  - A door still open in ARMED re-trips on the next cycle.
- Not defined: ALARM holds until `disarm_req`; `SIREN_TIMEOUT` is unused.

Decomposition:
- Shared package `alarm_pkg`:
  - state encoding constants (DISARMED..ALARM)
  - `NUM_DOORS`=5, `NUM_ALARM_ZONES`=4, `ENTRY_DOOR_IDX`=4.
- Sub-module `door_debounce`: synchroniser plus counter for one bit, parameterised by `DEBOUNCE_CYCLES`, instantiated 5× via generate.
- FSM and timer stay in the top of this block.

Test Plan (`DEBOUNCE_CYCLES`=4, `EXIT_DELAY`=8, `ENTRY_DELAY`=8):
- Debounce filtering:
  - A 3-cycle high pulse on `door_raw[2]` leaves `opening`=0.
  - A held high rises `opening[2]` exactly 6 cycles after the edge.
- Arm refused: with door 1 open, `arm_req` gives `arm_reject` for 1 cycle and `state`=0. After the door closes, `arm_req` gives `state`=1, then 2 after 8 cycles.
- Instant zone trip: ARMED, open door 3 gives `state`=4, `siren`=1, `alarm`=4'b1000. `disarm_req` then gives `siren`=0, `state`=0, `alarm` still 4'b1000. A new arm clears `alarm`=0.
- Entry-delay paths:
  - ARMED, open door 4 gives `state`=3; `disarm_req` at cycle 5 gives `state`=0 with `siren` never set.
  - Repeat without disarm: `state`=4 after 8 cycles, `alarm`=0.
- Simultaneous events:
  - `arm_req` and `disarm_req` in the same cycle in DISARMED leaves `state`=0.
  - Doors 0 and 4 debounced-open in the same cycle while ARMED gives ALARM with `alarm`=4'b0001.
- Reset mid-alarm: assert `reset_n`=0 asynchronously during ALARM; all outputs are 0 before the next clock edge.
